sram_mem_ctrl: RTL
==================

# sram_mem_ctrl

Memory-side responder for the MEM stage of the ARM pipeline. It accepts the MEM stage's 32-bit word read/write requests (MEM_R_EN / MEM_W_EN, ALU result as address, Val_RM as store data) and serves them from an external 16-bit asynchronous SRAM as two half-word accesses. It deasserts `ready` while busy; the top level uses `~ready` as the pipeline freeze. Read data feeds MEM_stage_Reg.

## Interface
- `ACCESS_CYCLES`, default 2: clock cycles per half-word SRAM access. Legal values are ≥ 2.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.
- `clk` input 1: the single clock. All state changes on the rising edge.
- `rst` input 1: reset, asynchronous, active-low.
- `rd_en` input 1: read request (MEM_R_EN).
- `wr_en` input 1: write request (MEM_W_EN).
- `address` input 32: byte address (ALU result).
- `write_data` input 32: store data (Val_RM).
- `read_data` output 32: loaded word.
- `ready` output 1: request complete or no request. Combinational.
- `sram_addr` output 18: SRAM half-word address.
- `sram_dq_out` output 16: SRAM write data.
- `sram_dq_oe` output 1: 1 = drive the DQ bus. The top level builds the tristate.
- `sram_dq_in` input 16: SRAM read data.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` outputs, 1 each: SRAM strobes, active-low.

## Operation
- States: IDLE, LOW, HIGH, DONE.
- `req = rd_en | wr_en`.
- Address mapping:
  - `off = address - BASE_ADDR`, a 32-bit wrap-around subtraction.
  - `w = off[18:2]`.
  - LOW phase uses `sram_addr = {w, 1'b0}`; HIGH phase uses `{w, 1'b1}`.
  - `address[1:0]` is ignored. Higher bits are truncated with no range check.
- Transitions:
  - IDLE: if `req`, latch `address`, `write_data`, and `op = wr_en`, then go to LOW. Otherwise stay in IDLE.
  - LOW: stays for ACCESS_CYCLES cycles (phase counter), then goes to HIGH.
  - HIGH: stays for ACCESS_CYCLES cycles, then goes to DONE.
  - DONE: one cycle, then goes to IDLE unconditionally.
- If `rd_en` and `wr_en` are both set, the write wins and the read is not performed.
- Ready: `ready = ~req | (state == DONE)`.
- Initiator rule: `rd_en`, `wr_en`, `address` and `write_data` stay stable from assertion until the cycle `ready` = 1. Operands come from the latched copies, so mid-access input changes do not corrupt the current access.
- Strobes:
  - In IDLE and DONE: `ce_n`, `ub_n`, `lb_n`, `oe_n`, `we_n` = 1 and `dq_oe` = 0.
  - In LOW and HIGH: `ce_n`, `ub_n`, `lb_n` = 0.
- Read phase:
  - `oe_n` = 0, `we_n` = 1, `dq_oe` = 0.
  - On the last cycle of LOW, `sram_dq_in` is registered into `read_data[15:0]`.
  - On the last cycle of HIGH, it is registered into `read_data[31:16]`.
- Write phase:
  - `oe_n` = 1 and `dq_oe` = 1.
  - `dq_out` = latched `write_data[15:0]` in LOW, `[31:16]` in HIGH.
  - `we_n` = 0 for the first ACCESS_CYCLES-1 cycles of the phase and 1 on its last cycle. Address and data are held for that last cycle.
- `read_data` holds its value until the next read overwrites it. Writes do not change it.

## Timing
- Reset (`rst` = 0, asynchronous), from any state including mid-access:
  - state = IDLE, counter = 0, `read_data` = 0.
  - `sram_addr` = 0, `dq_out` = 0, `dq_oe` = 0.
  - All strobes = 1.
  - `ready` = `~req`.
  - An access in flight is abandoned. A write may be partially done; that is accepted.
- Latency, with `req` first seen in IDLE at cycle 0:
  - LOW occupies cycles 1..A and HIGH occupies cycles A+1..2A, where A = ACCESS_CYCLES.
  - DONE is cycle 2A+1, where `ready` = 1.
  - `ready` = 0 for 2A+1 cycles.
  - With A = 2: `ready` is low in cycles 0–4 and high in cycle 5.
- `read_data` is valid in the DONE cycle and is captured by MEM_stage_Reg at the end of it.
- Back-to-back requests: the controller returns to IDLE after DONE. A new request seen in IDLE starts at the next edge, so there is one IDLE cycle with `ready` = 0 between requests.
- No request: the FSM stays in IDLE and `ready` = 1 continuously.

## Test plan
- Reset, then no request for 10 cycles:
  - `ready` = 1 and all strobes = 1 throughout.
  - `read_data` = 0, `dq_oe` = 0.
- Write 0xDEADBEEF to 1024 with A = 2:
  - The SRAM model receives half-word 0 = 0xBEEF, then half-word 1 = 0xDEAD.
  - `we_n` pulses low for one cycle per phase.
  - `ready` is low for 5 cycles, then high for 1 cycle.
- Read from 1024 after that write:
  - `read_data` = 0xDEADBEEF in the DONE cycle.
  - `oe_n` = 0 during LOW/HIGH and `dq_oe` = 0 throughout.
- Write 0x12345678 to 1028, then read it back-to-back:
  - The write drives SRAM addresses 2 and 3.
  - The read returns 0x12345678.
  - Exactly one IDLE cycle separates the two accesses.
- Assert `rd_en` and `wr_en` together, address 1032, data 0xCAFEF00D:
  - The write is performed.
  - `read_data` keeps its previous value.
- Pull `rst` low during HIGH of a read:
  - Outputs take their reset values immediately, with no clock needed.
  - After release with the request still held, a full 2A+2-cycle access restarts and returns the correct data.

Source files
------------

// File: rtl/sram_mem_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : sram_mem_ctrl
// Brief   : MEM-stage word access served as two half-word accesses on a
//           16-bit asynchronous SRAM; ready low while busy.
// Revision: 1.0
// ============================================================================
module sram_mem_ctrl #(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    localparam int          c_CW       = (ACCESS_CYCLES > 2) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(ACCESS_CYCLES - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOW  = 2'd1;
    localparam logic [1:0] c_HIGH = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic [1:0]      r_state;
    logic [1:0]      w_next_state;
    logic [c_CW-1:0] r_cnt;
    logic [31:0]     r_addr;
    logic [31:0]     r_wdata;
    logic            r_op;
    logic [31:0]     r_rdata;
    logic            w_req;
    logic            w_active;
    logic            w_last;
    logic [16:0]     w_word;

    assign w_req    = rd_en | wr_en;
    assign w_active = (r_state == c_LOW) || (r_state == c_HIGH);
    assign w_last   = w_active && (r_cnt == c_LAST);
    // Word index relative to the SRAM window; byte lane bits and anything above bit 18 drop out.
    assign w_word   = 17'((r_addr - BASE_ADDR) >> 2);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (w_req)  w_next_state = c_LOW;
            c_LOW:   if (w_last) w_next_state = c_HIGH;
            c_HIGH:  if (w_last) w_next_state = c_DONE;
            c_DONE:  w_next_state = c_IDLE;
            default: w_next_state = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_op    <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_active && !w_last) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
            if (r_state == c_IDLE && w_req) begin
                r_addr  <= address;
                r_wdata <= write_data;
                r_op    <= wr_en;
            end
            // Sample the SRAM on the final cycle of each read phase, after its access time.
            if (w_last && !r_op) begin
                if (r_state == c_HIGH) begin
                    r_rdata[31:16] <= sram_dq_in;
                end else begin
                    r_rdata[15:0] <= sram_dq_in;
                end
            end
        end
    end

    always_comb begin
        read_data   = r_rdata;
        ready       = ~w_req | (r_state == c_DONE);
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_ce_n   = 1'b1;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_ub_n   = 1'b1;
        sram_lb_n   = 1'b1;
        if (w_active) begin
            sram_ce_n = 1'b0;
            sram_ub_n = 1'b0;
            sram_lb_n = 1'b0;
            sram_addr = {w_word, (r_state == c_HIGH)};
            if (r_op) begin
                sram_dq_oe  = 1'b1;
                sram_dq_out = (r_state == c_HIGH) ? r_wdata[31:16] : r_wdata[15:0];
                // Release WE a cycle early so address and data hold past the write edge.
                sram_we_n   = w_last;
            end else begin
                sram_oe_n = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
